// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings and framing constants
// for the receive and transmit paths.
package uart_rx_pkg;

    localparam int DATA_BITS          = 8;
    localparam int MIN_CYCLES_PER_BIT = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: baud setting, line,
// received-byte handshake and sticky error flags.
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_SCALE_BITS = 16
) ();

    logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit;
    logic                        rx;
    logic                        busy;
    logic [DATA_BITS-1:0]        dataOut;
    logic                        dataAvailable;
    logic                        dataRead;
    logic                        framingError;
    logic                        overrunError;
    logic                        clearErrors;

    modport master (
        output cyclesPerBit, rx, dataRead, clearErrors,
        input  busy, dataOut, dataAvailable,
        input  framingError, overrunError
    );

    modport slave (
        input  cyclesPerBit, rx, dataRead, clearErrors,
        output busy, dataOut, dataAvailable,
        output framingError, overrunError
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with a history flop for falling-edge
// detection of an asynchronous, idle-high input.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rxSync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rxSync_o = sync_q;
    assign fall_o   = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, single-byte holding register
// with available/read handshake, sticky framing and overrun errors.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_SCALE_BITS = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam logic [CLOCK_SCALE_BITS-1:0] CNT_ONE = 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic rxSync;
    logic startFall;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (bus.rx),
        .rxSync_o (rxSync),
        .fall_o   (startFall)
    );

    rx_state_e                   state_q, state_d;
    logic [CLOCK_SCALE_BITS-1:0] delay_q, delay_d;
    logic [2:0]                  bit_q, bit_d;
    logic [DATA_BITS-1:0]        shift_q, shift_d;
    logic                        commit_q, commit_d;
    logic [DATA_BITS-1:0]        dataOut_q, dataOut_d;
    logic                        avail_q, avail_d;
    logic                        frameErr_q, frameErr_d;
    logic                        overErr_q, overErr_d;
    logic                        frameSet;

    logic [CLOCK_SCALE_BITS-1:0] halfBit;
    logic [CLOCK_SCALE_BITS-1:0] lastCnt;

    assign halfBit = bus.cyclesPerBit >> 1;
    assign lastCnt = bus.cyclesPerBit - CNT_ONE;

    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q + CNT_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        commit_d = 1'b0;
        frameSet = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                delay_d = '0;
                if (startFall) state_d = RX_START;
            end
            RX_START: begin
                if (delay_q == halfBit) begin
                    delay_d = '0;
                    bit_d   = '0;
                    state_d = rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (delay_q == lastCnt) begin
                    delay_d        = '0;
                    shift_d[bit_q] = rxSync;
                    if (bit_q == LAST_BIT) state_d = RX_STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (delay_q == lastCnt) begin
                    delay_d = '0;
                    if (rxSync) begin
                        commit_d = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        frameSet = 1'b1;
                        state_d  = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                // a held-low break line must not look like a new start
                delay_d = '0;
                if (rxSync) state_d = RX_IDLE;
            end
            default: begin
                delay_d = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        dataOut_d  = dataOut_q;
        avail_d    = avail_q;
        frameErr_d = frameErr_q;
        overErr_d  = overErr_q;
        if (bus.clearErrors) begin
            frameErr_d = 1'b0;
            overErr_d  = 1'b0;
        end
        if (frameSet) frameErr_d = 1'b1;
        if (bus.dataRead) avail_d = 1'b0;
        // a read in the commit cycle frees the holding register
        if (commit_q) begin
            if (!avail_q || bus.dataRead) begin
                dataOut_d = shift_q;
                avail_d   = 1'b1;
            end else begin
                overErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RX_IDLE;
            delay_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            commit_q   <= 1'b0;
            dataOut_q  <= '0;
            avail_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            commit_q   <= commit_d;
            dataOut_q  <= dataOut_d;
            avail_q    <= avail_d;
            frameErr_q <= frameErr_d;
            overErr_q  <= overErr_d;
        end
    end

    assign bus.busy          = (state_q != RX_IDLE);
    assign bus.dataOut       = dataOut_q;
    assign bus.dataAvailable = avail_q;
    assign bus.framingError  = frameErr_q;
    assign bus.overrunError  = overErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames in, received bytes
// popped and compared by an independent monitor.
module tb_uart_rx;

    localparam int C = 16;

    logic clk = 1'b0;
    logic rst;

    uart_rx_if #(.CLOCK_SCALE_BITS(16)) bus ();

    uart_rx #(.CLOCK_SCALE_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    bit   autoRead = 1'b1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b,
                             input logic stopBit,
                             input bit chkBusy);
        bus.rx = 1'b0;
        if (chkBusy) begin
            repeat (2) @(negedge clk);
            check("busy_before_detect", bus.busy, 0);
            @(negedge clk);
            check("busy_after_3clk", bus.busy, 1);
            repeat (C - 3) @(negedge clk);
        end else begin
            repeat (C) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (C) @(negedge clk);
        end
        bus.rx = stopBit;
        repeat (C) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compares each newly presented byte, optionally consumes it
    initial begin
        bit handled = 1'b0;
        bit rdPend  = 1'b0;
        bus.dataRead = 1'b0;
        forever begin
            @(negedge clk);
            if (rdPend) begin
                bus.dataRead = 1'b0;
                rdPend  = 1'b0;
                handled = 1'b0;
            end else if (bus.dataAvailable) begin
                if (!handled) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte actual=%02h required=none",
                                 bus.dataOut);
                    end else begin
                        check("rx_byte", bus.dataOut, exp_q.pop_front());
                    end
                    handled = 1'b1;
                end
                if (autoRead) begin
                    bus.dataRead = 1'b1;
                    rdPend = 1'b1;
                end
            end
        end
    end

    initial begin
        bit sawBusy;
        rst = 1'b0;
        bus.rx = 1'b1;
        bus.cyclesPerBit = 16'(C);
        bus.clearErrors = 1'b0;
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_dataOut", bus.dataOut, 0);
        check("rst_avail", bus.dataAvailable, 0);
        check("rst_frame", bus.framingError, 0);
        check("rst_over", bus.overrunError, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, 1'b1);
        drain("drain_55");
        check("frame_55", bus.framingError, 0);
        check("over_55", bus.overrunError, 0);

        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h3C);
        send_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        drain("drain_b2b");
        check("over_b2b", bus.overrunError, 0);

        autoRead = 1'b0;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drain("drain_ovr");
        check("ovr_dataOut", bus.dataOut, 8'h12);
        check("ovr_flag", bus.overrunError, 1);
        check("ovr_avail", bus.dataAvailable, 1);
        bus.clearErrors = 1'b1;
        @(negedge clk);
        bus.clearErrors = 1'b0;
        check("ovr_cleared", bus.overrunError, 0);
        check("ovr_dataOut_kept", bus.dataOut, 8'h12);
        autoRead = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_consumed", bus.dataAvailable, 0);

        send_byte(8'hFF, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("fe_flag", bus.framingError, 1);
        check("fe_avail", bus.dataAvailable, 0);
        check("fe_hold_busy", bus.busy, 1);
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        check("fe_idle", bus.busy, 0);
        check("fe_avail_after", bus.dataAvailable, 0);
        bus.clearErrors = 1'b1;
        @(negedge clk);
        bus.clearErrors = 1'b0;
        check("fe_cleared", bus.framingError, 0);

        sawBusy = 1'b0;
        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy) sawBusy = 1'b1;
        end
        check("gl_saw_busy", sawBusy, 1);
        check("gl_idle", bus.busy, 0);
        check("gl_avail", bus.dataAvailable, 0);
        check("gl_frame", bus.framingError, 0);
        check("gl_over", bus.overrunError, 0);

        bus.rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = (8'h99 >> i) & 8'h01;
            repeat (C) @(negedge clk);
        end
        bus.rx = 1'b1;
        repeat (C / 2) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_dataOut", bus.dataOut, 0);
        check("mid_rst_avail", bus.dataAvailable, 0);
        check("mid_rst_errs", {bus.framingError, bus.overrunError}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 1'b0);
        drain("drain_81");
        check("post_frame", bus.framingError, 0);
        check("post_over", bus.overrunError, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1, LSB first, idle-high line.
- Receive counterpart of the peripheral's transmit path; shares the `cyclesPerBit` programming model, so one baud register drives both directions.
- Synchronises `rx`, validates the start bit at mid-bit, samples each data bit at mid-bit and checks the stop bit.
- Holds one received byte with an available/read handshake and reports framing and overrun errors.

Parameters:
- `CLOCK_SCALE_BITS`, default 16: width of the bit-period divider and of `cyclesPerBit`.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cyclesPerBit` input `CLOCK_SCALE_BITS`: bit period in clocks = ((CLK_FREQ + BAUD) / BAUD) - 1. Minimum 4; sampled continuously and held stable while `busy`.
- `rx` input 1: serial input, asynchronous to `clk`.
- `busy` output 1: high while a frame is in progress (any state other than IDLE).
- `dataOut` output 8: last successfully received byte.
- `dataAvailable` output 1: high while `dataOut` holds an unread byte.
- `dataRead` input 1: single-cycle pulse; consumes the held byte.
- `framingError` output 1: sticky; the stop bit was sampled low.
- `overrunError` output 1: sticky; a byte completed while `dataAvailable` was already set.
- `clearErrors` input 1: single-cycle pulse; clears both sticky errors.

Behaviour:
- Reset (rst low, async):
  - State is IDLE; bit and clock counters are 0; synchroniser flops are 1.
  - `dataOut` = 0x00; `dataAvailable`, `framingError`, `overrunError` and `busy` are all 0.
  - Reset mid-frame abandons the frame; nothing is committed.
- Synchroniser:
  - Two flops on `rx` give `rxSync`, plus one history flop.
  - Start detect is `rxSync` falling (previous 1, current 0).
  - Input-to-detect latency is 3 clocks.
- Divider: `delayCounter` is `CLOCK_SCALE_BITS` wide and increments each cycle within a state. It resets to 0 on every state entry and on every bit sample; width wrap is impossible because `cyclesPerBit` is the bound.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on start detect, go to START with the counter at 0.
  - START: when the counter == (`cyclesPerBit` >> 1), sample `rxSync`.
    - Low: go to DATA, counter 0, bitCounter 0.
    - High: treat as a glitch and return to IDLE with no flags.
  - DATA: when the counter == `cyclesPerBit` - 1, sample `rxSync` into shift register bit [bitCounter] and reset the counter.
    - On bitCounter == 7, go to STOP.
    - Otherwise bitCounter increments (3-bit, no wrap use).
  - STOP: when the counter == `cyclesPerBit` - 1, sample `rxSync`.
    - High: commit the byte and go to IDLE. IDLE accepts a new start edge immediately, so back-to-back frames are supported.
    - Low: set `framingError`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxSync` == 1, then go to IDLE. This prevents a held-low/break line retriggering.
- Commit (the cycle after the stop sample):
  - If `dataAvailable` == 0, or `dataRead` is asserted in the same cycle: load `dataOut` and set `dataAvailable` = 1.
  - Else: keep the old `dataOut` (new byte dropped) and set `overrunError`.
- `dataRead`:
  - Clears `dataAvailable` the next cycle unless a commit coincides; a commit wins and `dataAvailable` stays 1.
  - Ignored when `dataAvailable` == 0.
- `clearErrors`: clears both errors. If an error sets in the same cycle, the set wins.
- `dataOut` is stable while `dataAvailable` == 1.

Decomposition:
- Shared UART package holds:
  - the state encodings (3-bit for rx; the tx 2-bit set stays alongside);
  - `DATA_BITS` = 8;
  - the minimum `cyclesPerBit` constant (4), used by both rx and tx.
- One natural sub-module: `uart_rx_sync`, the two-flop synchroniser plus falling-edge detector. It is reusable for other asynchronous inputs in the peripheral block.

Test Plan:
- `cyclesPerBit`=16; drive frame 0x55 (start, 10101010 LSB-first, stop) -> `busy` rises 3 clocks after the start edge; `dataAvailable`=1 with `dataOut`=0x55 one cycle after the stop sample; no errors.
- Two back-to-back frames 0xA3 then 0x3C with no idle gap, `dataRead` pulsed after the first -> both bytes delivered in order; `overrunError`=0.
- 0x12 received and not read, then 0x34 received -> `dataOut` stays 0x12 and `overrunError`=1. A `clearErrors` pulse clears it; `dataOut` is unchanged.
- Frame 0xFF with the stop bit driven low, line held low 100 clocks -> `framingError`=1; `dataAvailable` stays 0; no new frame starts until the line returns high.
- `rx` low pulse of 5 clocks (< half-bit of 8) in IDLE -> returns to IDLE; `busy` pulses briefly; no flags, `dataAvailable`=0.
- Assert `rst` low during DATA bit 4 of frame 0x99 -> all outputs go to reset values immediately. After release, a full 0x81 frame is received correctly.
